// File: rtl/rx_pkg.sv
// Shared types and default timing constants for the serial receive controller.
package rx_pkg;
  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_NUM_BITS     = 9;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_t;
endpackage

// File: rtl/rx_ctrl_flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after ROLLOVER.
// Single-cycle update, no backpressure; rollover_flag decodes the registered count.
module flex_counter #(
  parameter int WIDTH    = 4,
  parameter int ROLLOVER = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);
  localparam logic [WIDTH-1:0] ROLL = WIDTH'(ROLLOVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= (count == ROLL) ? '0 : count + 1'b1;
    end
  end

  assign rollover_flag = (count == ROLL);
endmodule

// File: rtl/rx_ctrl.sv
// Serial receive sequencer: start-bit check, mid-bit shift strobes, stop check, buffer load.
// Falling edge to load_buffer takes CLKS_PER_BIT/2 + NUM_BITS*CLKS_PER_BIT + 2 cycles; no backpressure.
module rx_ctrl
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_BITS     = DEF_NUM_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t state, state_nxt;
  logic          prev_in;
  logic          fall;
  logic [TW-1:0] timer;
  logic          timer_flag;
  logic          timer_clr, timer_en;
  logic          cnt_clr, cnt_en, cnt_flag;
  logic [CW-1:0] unused_bit_cnt;
  logic          strobe;
  logic          fe_set, fe_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prev_in       <= 1'b1;
      framing_error <= 1'b0;
    end else begin
      state   <= state_nxt;
      prev_in <= serial_in;
      if (fe_set) begin
        framing_error <= 1'b1;
      end else if (fe_clr) begin
        framing_error <= 1'b0;
      end
    end
  end

  assign fall   = prev_in & ~serial_in;
  assign strobe = (state == RECV) && timer_flag;

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    fe_set    = 1'b0;
    fe_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_clr = 1'b1;
        cnt_clr   = 1'b1;
        if (fall) state_nxt = START_CHK;
      end
      START_CHK: begin
        timer_en = 1'b1;
        // Half a bit period in: line still low means a genuine start bit.
        if (timer == HALF_LAST) begin
          timer_clr = 1'b1;
          if (!serial_in) begin
            state_nxt = RECV;
            fe_clr    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RECV: begin
        timer_en = 1'b1;
        cnt_en   = strobe;
        if (strobe && cnt_flag) state_nxt = STOP_CHK;
      end
      STOP_CHK: begin
        if (stop_bit) begin
          state_nxt = LOAD;
        end else begin
          fe_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  flex_counter #(.WIDTH(TW), .ROLLOVER(CLKS_PER_BIT - 1)) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (timer_clr),
    .count_enable (timer_en),
    .count        (timer),
    .rollover_flag(timer_flag)
  );

  flex_counter #(.WIDTH(CW), .ROLLOVER(NUM_BITS - 1)) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clr),
    .count_enable (cnt_en),
    .count        (unused_bit_cnt),
    .rollover_flag(cnt_flag)
  );

  // Pulses are suppressed while reset is held so a mid-frame reset never leaks a strobe.
  assign shift_strobe = strobe & ~rst;
  assign load_buffer  = (state == LOAD) & ~rst;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl with a scoreboard of expected strobe/load cycles and a model shift register.
module tb_rx_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic stop_bit;
  logic shift_strobe, load_buffer, framing_error, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [8:0] sr = '0;

  int          exp_strobe[$];
  int          exp_load[$];
  logic [7:0]  exp_data[$];

  rx_ctrl #(.CLKS_PER_BIT(10), .NUM_BITS(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .stop_bit     (stop_bit),
    .shift_strobe (shift_strobe),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (shift_strobe) sr <= {serial_in, sr[8:1]};
  end
  assign stop_bit = sr[8];

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (shift_strobe || load_buffer)
      chk("strobe_load_exclusive", int'(shift_strobe & load_buffer), 0);
    if (shift_strobe) begin
      chk("strobe_expected", int'(exp_strobe.size() > 0), 1);
      if (exp_strobe.size() > 0) chk("strobe_cycle", cyc, exp_strobe.pop_front());
    end
    if (load_buffer) begin
      chk("load_expected", int'(exp_load.size() > 0), 1);
      if (exp_load.size() > 0) begin
        chk("load_cycle", cyc, exp_load.pop_front());
        chk("load_data", int'(sr[7:0]), int'(exp_data.pop_front()));
      end
    end
  end

  // Drives one frame starting this cycle; stop_at truncates it (cycles driven = min(98, stop_at)).
  task automatic send_frame(input logic [7:0] d, input logic s, input int glitch, input int stop_at);
    logic [9:0] f;
    int t0;
    f  = {s, d, 1'b0};
    t0 = cyc;
    for (int k = 0; k < 9; k++)
      if (15 + 10 * k < stop_at) exp_strobe.push_back(t0 + 15 + 10 * k);
    if (s && stop_at > 97) begin
      exp_load.push_back(t0 + 97);
      exp_data.push_back(d);
    end
    for (int i = 0; i < 98 && i < stop_at; i++) begin
      serial_in = (i == glitch) ? 1'b0 : f[i / 10];
      tick();
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    int busy_cnt;
    rst = 1'b1;
    serial_in = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(shift_strobe), 0);
    chk("rst_load", int'(load_buffer), 0);
    chk("rst_fe", int'(framing_error), 0);
    rst = 1'b0;

    // Idle line
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    chk("idle_busy_cycles", bad, 0);

    // Valid frame 0xA5
    send_frame(8'hA5, 1'b1, -1, 1000);
    chk("valid_fe", int'(framing_error), 0);
    chk("valid_idle_after", int'(busy), 0);
    idle(5);

    // Framing error
    send_frame(8'hA5, 1'b0, -1, 1000);
    chk("ferr_set", int'(framing_error), 1);
    idle(20);
    chk("ferr_sticky", int'(framing_error), 1);

    // False start: low for 3 cycles
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      serial_in = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 6) chk("false_start_idle", int'(busy), 0);
      tick();
    end
    chk("false_start_busy_cycles", busy_cnt, 5);
    chk("false_start_fe_held", int'(framing_error), 1);
    idle(5);

    // Good frame clears the sticky error
    send_frame(8'h0F, 1'b1, -1, 1000);
    chk("ferr_cleared", int'(framing_error), 0);
    idle(5);

    // Reset after strobe 4
    send_frame(8'hC3, 1'b1, -1, 46);
    rst = 1'b1;
    serial_in = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_strobe", int'(shift_strobe), 0);
    chk("midrst_load", int'(load_buffer), 0);
    chk("midrst_fe", int'(framing_error), 0);
    idle(15);
    send_frame(8'h3C, 1'b1, -1, 1000);
    idle(5);

    // Back-to-back frames, second with a falling-edge glitch mid-bit
    send_frame(8'h5A, 1'b1, -1, 1000);
    send_frame(8'hA5, 1'b1, 12, 1000);
    chk("b2b_fe", int'(framing_error), 0);
    idle(10);

    chk("strobe_queue_empty", exp_strobe.size(), 0);
    chk("load_queue_empty", exp_load.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rx_ctrl.md
RX_CTRL -- requirements
Module: rx_ctrl

Parameters
REQ-001 The block SHALL provide parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit period; legal range 4..1023, even values only.
REQ-002 The block SHALL provide parameter NUM_BITS, default 9, meaning shift strobes per frame (8 data + 1 stop).

Interface
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 serial_in  input  1  raw serial line, idle high, already synchronized upstream.
REQ-006 stop_bit  input  1  stop bit value from the 9-bit receive shift register.
REQ-007 shift_strobe  output  1  one-cycle pulse commanding the shift register to shift in serial_in.
REQ-008 load_buffer  output  1  one-cycle pulse commanding the RX buffer to capture packet_data.
REQ-009 framing_error  output  1  sticky flag; last frame had stop_bit = 0.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 States SHALL be IDLE, START_CHK, RECV, STOP_CHK and LOAD.
REQ-012 The block SHALL register serial_in into prev_in (reset value 1); a falling edge is prev_in=1 and serial_in=0.
REQ-013 IDLE SHALL go to START_CHK on a falling edge and clear the bit timer and bit counter.
REQ-014 START_CHK SHALL count CLKS_PER_BIT/2 cycles, then sample serial_in:
  - 0: go to RECV and clear framing_error.
  - 1: false start; go to IDLE with no strobe.
REQ-015 In RECV the bit timer SHALL count 0..CLKS_PER_BIT-1 and wrap to 0.
REQ-016 shift_strobe SHALL be high for exactly the cycle where the timer equals CLKS_PER_BIT-1 in RECV, giving one strobe per bit period at mid-bit.
REQ-017 The bit counter SHALL increment on each strobe; the state SHALL go from RECV to STOP_CHK on the cycle after strobe number NUM_BITS.
REQ-018 STOP_CHK SHALL last exactly one cycle:
  - stop_bit=1: go to LOAD.
  - stop_bit=0: set framing_error and go to IDLE.
REQ-019 LOAD SHALL assert load_buffer for exactly one cycle, then go to IDLE.
REQ-020 A new falling edge SHALL be ignored in every state except IDLE.
REQ-021 shift_strobe and load_buffer SHALL never be high in the same cycle.
REQ-022 Latency SHALL be CLKS_PER_BIT/2 + NUM_BITS*CLKS_PER_BIT + 2 cycles from falling edge to load_buffer.
REQ-023 serial_in changes during RECV SHALL affect only the sampled data, never the timing.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL enter IDLE, zero the timer and bit counter, set prev_in=1, and drive shift_strobe=0, load_buffer=0, framing_error=0, busy=0.
REQ-025 Reset SHALL take priority over all transitions, including mid-frame; no pulse SHALL be emitted in the reset cycle or the cycle after it.

Structure
REQ-026 The state enum type rx_state_t SHALL reside in shared package rx_pkg.
REQ-027 The default CLKS_PER_BIT and NUM_BITS constants SHALL reside in shared package rx_pkg.
REQ-028 The bit timer SHALL be a sub-module flex_counter (parameterized width, rollover value, clear and count_enable inputs, rollover_flag output), instantiated twice: once as bit timer, once as bit counter.
REQ-029 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from serial_in to any output.

Verification (CLKS_PER_BIT=10, NUM_BITS=9)
REQ-030 Valid frame: start bit, data 0xA5 LSB first, stop=1 -> 9 strobes spaced 10 cycles apart, first strobe 15 cycles after the falling edge; load_buffer once at cycle 97; framing_error=0.
REQ-031 Framing error: same frame with stop_bit=0 -> no load_buffer; framing_error=1 and held until the next confirmed start bit.
REQ-032 False start: serial_in low for 3 cycles, then high -> return to IDLE at cycle 5; zero strobes; busy high for 5 cycles.
REQ-033 Reset mid-frame: rst=1 after strobe 4 -> all outputs 0 next cycle; a subsequent valid frame is received correctly.
REQ-034 Back-to-back frames: second falling edge 1 cycle after load_buffer -> second frame is accepted; a falling edge injected during RECV is ignored.
REQ-035 Idle line: serial_in held at 1 for 200 cycles -> busy, shift_strobe and load_buffer stay 0.
